// File: rtl/mca_operand_feeder.sv
// mca_operand_feeder: control-bit window and coefficient store feeding
// the multi-cycle accumulator. Optional readback: MCA_FEEDER_READBACK_EN.
module mca_operand_feeder #(
   parameter int WIDTH_COEFFICIENT = 32,
   parameter int NUM_ADDITIONS     = 16,
   parameter int DOWNSAMPLE        = 16,
   parameter int ADDR_W = (NUM_ADDITIONS > 1) ? $clog2(NUM_ADDITIONS) : 1
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         enable,
   input  logic                         s_valid,
   input  logic                         s_in,
   input  logic                         cfg_we,
   input  logic [ADDR_W-1:0]            cfg_addr,
   input  logic signed [WIDTH_COEFFICIENT-1:0] cfg_wdata,
`ifdef MCA_FEEDER_READBACK_EN
   input  logic [ADDR_W-1:0]            cfg_raddr,
   output logic signed [WIDTH_COEFFICIENT-1:0] cfg_rdata,
`endif
   output logic signed [NUM_ADDITIONS-1:0][WIDTH_COEFFICIENT-1:0] operands,
   output logic [NUM_ADDITIONS-1:0]     S_values,
   output logic                         start,
   output logic                         busy,
   output logic                         overrun,
   output logic                         cfg_err
);

   localparam int CNT_W = (DOWNSAMPLE > 1) ? $clog2(DOWNSAMPLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DOWNSAMPLE - 1);
   localparam logic [3:0] BUSY_LAST = 4'd15;

   typedef enum logic [1:0] {
      FEED_IDLE,
      FEED_START,
      FEED_BUSY
   } state_t;

   state_t state, state_next;

   logic [NUM_ADDITIONS-1:0] window;
   logic [NUM_ADDITIONS-1:0] window_next;
   logic [NUM_ADDITIONS-1:0] s_hold;
   logic [CNT_W-1:0]         sample_cnt;
   logic [3:0]               busy_cnt;
   logic signed [NUM_ADDITIONS-1:0][WIDTH_COEFFICIENT-1:0] coeff;

   logic accept;
   logic trigger;
   logic snap;
   logic wr_req;
   logic addr_ok;

   assign accept  = enable & s_valid;
   assign trigger = accept & (sample_cnt == CNT_LAST);
   assign wr_req  = enable & cfg_we;
   assign addr_ok = int'(cfg_addr) < NUM_ADDITIONS;

   assign operands = coeff;
   assign S_values = s_hold;

   // window as it will look after this cycle's sample is shifted in
   always_comb begin
      window_next    = window << 1;
      window_next[0] = s_in;
   end

   // sliding control-bit window and downsample counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         window     <= '0;
         sample_cnt <= '0;
      end else if (accept) begin
         window     <= window_next;
         sample_cnt <= (sample_cnt == CNT_LAST) ? '0
                                                : sample_cnt + CNT_W'(1);
      end
   end

   // next state and start/busy decode
   always_comb begin
      state_next = state;
      start      = 1'b0;
      busy       = 1'b0;
      snap       = 1'b0;
      unique case (state)
         FEED_IDLE: begin
            if (trigger) begin
               snap       = 1'b1;
               state_next = FEED_START;
            end
         end
         FEED_START: begin
            busy  = 1'b1;
            start = enable;
            if (enable) state_next = FEED_BUSY;
         end
         FEED_BUSY: begin
            busy = 1'b1;
            if (enable && busy_cnt == BUSY_LAST)
               state_next = FEED_IDLE;
         end
         default: state_next = FEED_IDLE;
      endcase
   end

   // state register; busy_cnt walks the accumulator's 16 adding cycles
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= FEED_IDLE;
         busy_cnt <= '0;
      end else if (enable) begin
         state <= state_next;
         if (state == FEED_START)
            busy_cnt <= '0;
         else if (state == FEED_BUSY)
            busy_cnt <= busy_cnt + 4'd1;
      end
   end

   // snapshot hold; a trigger while busy is dropped and flagged
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s_hold  <= '0;
         overrun <= 1'b0;
      end else begin
         if (snap)
            s_hold <= window_next;
         if (trigger && state != FEED_IDLE)
            overrun <= 1'b1;
      end
   end

   // coefficient store; writes only land while idle and in range
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         coeff   <= '0;
         cfg_err <= 1'b0;
      end else if (wr_req) begin
         if (state == FEED_IDLE && addr_ok)
            coeff[cfg_addr] <= cfg_wdata;
         else
            cfg_err <= 1'b1;
      end
   end

`ifdef MCA_FEEDER_READBACK_EN
   logic raddr_ok;
   assign raddr_ok = int'(cfg_raddr) < NUM_ADDITIONS;

   // registered coefficient readback, zero for out-of-range addresses
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         cfg_rdata <= '0;
      else if (enable)
         cfg_rdata <= raddr_ok ? coeff[cfg_raddr] : '0;
   end
`endif

endmodule

// File: tb/tb_mca_operand_feeder.sv
// tb_mca_operand_feeder: directed vectors for the operand feeder,
// default build plus a DOWNSAMPLE=4 / 12-tap instance for corner cases.
module tb_mca_operand_feeder;

   logic clk = 1'b0;
   logic resetn;
   logic enable;

   always #5 clk = ~clk;

   logic              a_sv, a_si, a_we;
   logic [3:0]        a_addr;
   logic [31:0]       a_wd;
   logic [15:0][31:0] a_ops;
   logic [15:0]       a_S;
   logic              a_start, a_busy, a_over, a_cerr;

   logic              b_sv, b_si, b_we;
   logic [3:0]        b_addr;
   logic [31:0]       b_wd;
   logic [11:0][31:0] b_ops;
   logic [11:0]       b_S;
   logic              b_start, b_busy, b_over, b_cerr;

`ifdef MCA_FEEDER_READBACK_EN
   logic [3:0]  a_raddr, b_raddr;
   logic [31:0] a_rdata, b_rdata;
`endif

   mca_operand_feeder dut_a (
      .clk(clk), .resetn(resetn), .enable(enable),
      .s_valid(a_sv), .s_in(a_si), .cfg_we(a_we),
      .cfg_addr(a_addr), .cfg_wdata(a_wd),
`ifdef MCA_FEEDER_READBACK_EN
      .cfg_raddr(a_raddr), .cfg_rdata(a_rdata),
`endif
      .operands(a_ops), .S_values(a_S), .start(a_start),
      .busy(a_busy), .overrun(a_over), .cfg_err(a_cerr)
   );

   mca_operand_feeder #(
      .NUM_ADDITIONS(12), .DOWNSAMPLE(4)
   ) dut_b (
      .clk(clk), .resetn(resetn), .enable(enable),
      .s_valid(b_sv), .s_in(b_si), .cfg_we(b_we),
      .cfg_addr(b_addr), .cfg_wdata(b_wd),
`ifdef MCA_FEEDER_READBACK_EN
      .cfg_raddr(b_raddr), .cfg_rdata(b_rdata),
`endif
      .operands(b_ops), .S_values(b_S), .start(b_start),
      .busy(b_busy), .overrun(b_over), .cfg_err(b_cerr)
   );

   typedef struct {
      logic        sv;
      logic        si;
      logic        we;
      logic [3:0]  addr;
      logic [31:0] wd;
      logic        xs;
      logic        xb;
      logic [15:0] xsv;
      longint      xacc;
   } vec_t;

   vec_t vt[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(logic sv, logic si, logic we,
                               logic [3:0] addr, logic [31:0] wd,
                               logic xs, logic xb, logic [15:0] xsv,
                               longint xacc);
      vec_t v;
      v.sv = sv; v.si = si; v.we = we; v.addr = addr; v.wd = wd;
      v.xs = xs; v.xb = xb; v.xsv = xsv; v.xacc = xacc;
      return v;
   endfunction

   // what the downstream accumulator would produce from the held operands
   function automatic longint accsum(input logic [15:0] s,
                                     input logic [15:0][31:0] ops);
      longint acc = 0;
      for (int i = 0; i < 16; i++) begin
         if (s[i]) acc += longint'($signed(ops[i]));
         else      acc -= longint'($signed(ops[i]));
      end
      return acc;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", name, got, exp);
      end
   endtask

   task automatic feed_ones_a(input int n);
      for (int i = 0; i < n; i++) begin
         a_sv = 1'b1; a_si = 1'b1;
         tick();
      end
      a_sv = 1'b0; a_si = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; enable = 1'b1;
      a_sv = 0; a_si = 0; a_we = 0; a_addr = 0; a_wd = 0;
      b_sv = 0; b_si = 0; b_we = 0; b_addr = 0; b_wd = 0;
`ifdef MCA_FEEDER_READBACK_EN
      a_raddr = 0; b_raddr = 0;
`endif

      // phase 1: coefficients i+1, then 16 ones, then the 17-cycle hold
      for (int i = 0; i < 16; i++)
         vt.push_back(mk(0, 0, 1, 4'(i), 32'(i + 1), 0, 0, 16'h0, 0));
      for (int i = 0; i < 16; i++)
         vt.push_back(mk(1, 1, 0, 0, 0, i == 15, i == 15,
                         (i == 15) ? 16'hFFFF : 16'h0, 136));
      for (int i = 0; i < 17; i++)
         vt.push_back(mk(0, 0, 0, 0, 0, 0, i < 16, 16'hFFFF, 0));
      // phase 2: alternating samples starting with 1
      for (int i = 0; i < 16; i++)
         vt.push_back(mk(1, (i % 2) == 0, 0, 0, 0, i == 15, i == 15,
                         (i == 15) ? 16'hAAAA : 16'hFFFF, 8));
      for (int i = 0; i < 17; i++)
         vt.push_back(mk(0, 0, 0, 0, 0, 0, i < 16, 16'hAAAA, 0));

      #12;
      chk("rst_start", a_start, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_over", a_over, 0);
      chk("rst_cerr", a_cerr, 0);
      chk("rst_S", a_S, 0);
      chk("rst_ops_zero", a_ops == '0, 1);
      @(negedge clk);
      resetn = 1'b1;
      tick();

      // small instance: out-of-range write and overrun
      b_we = 1; b_addr = 4'd5; b_wd = 32'h55;
      tick();
      chk("b_wr_ok", b_ops[5], 32'h55);
      chk("b_cerr0", b_cerr, 0);
      b_addr = 4'd13; b_wd = 32'h77;
      tick();
      b_we = 0;
      chk("b_cerr_range", b_cerr, 1);
      chk("b_ops5_kept", b_ops[5], 32'h55);
      for (int n = 1; n <= 24; n++) begin
         b_sv = 1'b1;
         b_si = (n <= 4) || n == 21 || n == 23 || n == 24;
         tick();
         if (n == 3)  chk("b_start_n3", b_start, 0);
         if (n == 4) begin
            chk("b_start_n4", b_start, 1);
            chk("b_S_n4", b_S, 12'h00F);
         end
         if (n == 7)  chk("b_over_n7", b_over, 0);
         if (n == 8) begin
            chk("b_over_n8", b_over, 1);
            chk("b_S_kept_n8", b_S, 12'h00F);
            chk("b_start_n8", b_start, 0);
         end
         if (n == 20) chk("b_busy_n20", b_busy, 1);
         if (n == 21) chk("b_busy_n21", b_busy, 0);
         if (n == 23) chk("b_start_n23", b_start, 0);
         if (n == 24) begin
            chk("b_start_n24", b_start, 1);
            chk("b_S_n24", b_S, 12'h00B);
         end
      end
      b_sv = 1'b0; b_si = 1'b0;

      // table-driven phases on the default instance
      for (int k = 0; k < vt.size(); k++) begin
         a_sv = vt[k].sv; a_si = vt[k].si; a_we = vt[k].we;
         a_addr = vt[k].addr; a_wd = vt[k].wd;
         tick();
         n_vec++;
         if (a_start !== vt[k].xs || a_busy !== vt[k].xb ||
             a_S !== vt[k].xsv) begin
            n_err++;
            $display("FAIL vec%0d start/busy/S got %b/%b/%h want %b/%b/%h",
                     k, a_start, a_busy, a_S,
                     vt[k].xs, vt[k].xb, vt[k].xsv);
         end
         if (vt[k].xs)
            chk("acc_res", accsum(a_S, a_ops), vt[k].xacc);
      end
      a_sv = 0; a_si = 0; a_we = 0;

`ifdef MCA_FEEDER_READBACK_EN
      a_raddr = 4'd3;
      tick();
      chk("rdata3", a_rdata, 32'd4);
      b_raddr = 4'd13;
      tick();
      chk("rdata_oor", b_rdata, 0);
`endif

      // enable dropped for 5 cycles at busy_cnt=7
      feed_ones_a(16);
      chk("frz_start", a_start, 1);
      for (int i = 0; i < 8; i++) tick();
      enable = 1'b0;
      a_we = 1; a_addr = 4'd2; a_wd = 32'h99;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("frz_busy", a_busy, 1);
         chk("frz_start0", a_start, 0);
         chk("frz_S", a_S, 16'hFFFF);
      end
      chk("frz_cerr", a_cerr, 0);
      chk("frz_ops2", a_ops[2], 32'd3);
      enable = 1'b1;
      a_addr = 4'd3; a_wd = 32'hDEAD;
      for (int k = 1; k <= 9; k++) begin
         tick();
         a_we = 0;
         if (k == 1) begin
            chk("busywr_cerr", a_cerr, 1);
            chk("busywr_ops3", a_ops[3], 32'd4);
         end
         chk("frz_tail_busy", a_busy, k < 9);
      end
      chk("a_over0", a_over, 0);

      // async reset in the middle of the adding phase
      feed_ones_a(16);
      for (int i = 0; i < 11; i++) tick();
      chk("pre_rst_busy", a_busy, 1);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_busy", a_busy, 0);
      chk("mid_rst_start", a_start, 0);
      chk("mid_rst_S", a_S, 0);
      chk("mid_rst_ops", a_ops == '0, 1);
      chk("mid_rst_cerr", a_cerr, 0);
      @(negedge clk);
      resetn = 1'b1;
      feed_ones_a(15);
      chk("post_rst_n15", a_start, 0);
      feed_ones_a(1);
      chk("post_rst_start", a_start, 1);
      chk("post_rst_S", a_S, 16'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
